// File: rtl/serdes_pkg.sv
// Shared 8b/10b receive definitions: K28.5 code points and the alignment FSM encoding.
package serdes_pkg;

    localparam int unsigned WORD_BITS = 10;

    // K28.5 in both running disparities, bit 0 = first bit on the line.
    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    // True when a 10-bit window holds K28.5 of either disparity.
    function automatic logic is_k28_5(input logic [9:0] word);
        return (word == K28_5_RDN) || (word == K28_5_RDP);
    endfunction

endpackage

// File: rtl/comma_detect.sv
// Serial-to-window shifter with polarity correction and K28.5 match flag.
module comma_detect
    import serdes_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bit_i,
    input  logic       rxpol_i,
    output logic [9:0] window_o,
    output logic       match_o
);

    logic [9:0] window_q;
    logic [9:0] window_d;

    // Newest bit enters at the top so that after ten shifts bit 0 is the oldest bit.
    always_comb begin
        window_d = {bit_i ^ rxpol_i, window_q[9:1]};
    end

    // Window register; cleared by reset so a partial word never survives it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

    assign window_o = window_q;
    // Match is taken from the registered window, not the incoming bit.
    assign match_o  = is_k28_5(window_q);

endmodule

// File: rtl/comma_align.sv
// K28.5 comma aligner: hunts for commas, confirms LOCK_COMMAS aligned ones, then emits words.
module comma_align
    import serdes_pkg::*;
#(
    parameter int unsigned LOCK_COMMAS = 3,  // 1..15
    parameter int unsigned MAX_ERR     = 4   // 1..15
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       data_in,
    input  logic       rxpol,
    output logic [9:0] data_out,
    output logic       data_valid,
    output logic       is_comma,
    output logic       locked
);

    localparam logic [3:0] LockThresh = 4'(LOCK_COMMAS);
    localparam logic [3:0] ErrThresh  = 4'(MAX_ERR);
    localparam logic [3:0] LastPhase  = 4'(WORD_BITS - 1);

    logic [9:0]   window;
    logic         match;

    align_state_e state_q, state_d;
    logic [3:0]   phase_q, phase_d;
    logic [3:0]   comma_cnt_q, comma_cnt_d;
    logic [3:0]   err_cnt_q, err_cnt_d;
    logic [9:0]   data_out_q, data_out_d;
    logic         data_valid_q, data_valid_d;
    logic         is_comma_q, is_comma_d;
    logic         boundary;

    comma_detect u_detect (
        .clk_i    (reloj),
        .rst_i    (reset),
        .bit_i    (data_in),
        .rxpol_i  (rxpol),
        .window_o (window),
        .match_o  (match)
    );

    // Phase 0 means the window currently holds a full word on the locked grid.
    assign boundary = (phase_q == 4'd0);

    // Next-state, counter and output-register logic for the alignment FSM.
    always_comb begin
        state_d      = state_q;
        phase_d      = (phase_q == LastPhase) ? 4'd0 : phase_q + 4'd1;
        comma_cnt_d  = comma_cnt_q;
        err_cnt_d    = err_cnt_q;
        data_out_d   = data_out_q;
        is_comma_d   = is_comma_q;
        data_valid_d = 1'b0;

        case (state_q)
            HUNT: begin
                // Any comma defines the grid; phase 1 is the first bit of the next word.
                if (match) begin
                    phase_d     = 4'd1;
                    comma_cnt_d = 4'd1;
                    state_d     = (LockThresh == 4'd1) ? LOCKED : SYNC;
                end
            end

            SYNC: begin
                if (match) begin
                    if (boundary) begin
                        comma_cnt_d = comma_cnt_q + 4'd1;
                        if (comma_cnt_q + 4'd1 == LockThresh) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        // Comma off the grid: adopt its phase and restart confirmation.
                        phase_d     = 4'd1;
                        comma_cnt_d = 4'd1;
                    end
                end
            end

            LOCKED: begin
                if (boundary) begin
                    data_out_d   = window;
                    is_comma_d   = match;
                    data_valid_d = 1'b1;
                end
                if (match && !boundary) begin
                    if (err_cnt_q + 4'd1 == ErrThresh) begin
                        state_d     = HUNT;
                        phase_d     = 4'd0;
                        comma_cnt_d = 4'd0;
                        err_cnt_d   = 4'd0;
                    end else begin
                        err_cnt_d = err_cnt_q + 4'd1;
                    end
                end else if (match) begin
                    err_cnt_d = 4'd0;
                end
            end

            default: begin
                state_d     = HUNT;
                phase_d     = 4'd0;
                comma_cnt_d = 4'd0;
                err_cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counters and output registers; reset discards everything.
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            phase_q      <= 4'd0;
            comma_cnt_q  <= 4'd0;
            err_cnt_q    <= 4'd0;
            data_out_q   <= 10'h000;
            data_valid_q <= 1'b0;
            is_comma_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            comma_cnt_q  <= comma_cnt_d;
            err_cnt_q    <= err_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            is_comma_q   <= is_comma_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign is_comma   = is_comma_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_comma_align.sv
// Self-checking bench for comma_align against a word-level reference model.
module tb_comma_align;

    localparam logic [9:0] KN    = 10'h17C;
    localparam logic [9:0] KP    = 10'h283;
    localparam logic [9:0] D155  = 10'h155;
    localparam int         LOCKN = 3;
    localparam int         MAXE  = 4;

    logic       reloj   = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic       rxpol   = 1'b0;
    logic [9:0] data_out;
    logic       data_valid;
    logic       is_comma;
    logic       locked;

    int checks          = 0;
    int passed          = 0;
    int bitn            = 0;
    int lock_bit        = -1;
    int unlocked_cycles = 0;

    int         pv_bit[$];
    logic [9:0] pv_data[$];
    logic       pv_comma[$];

    // Reference model: last ten effective bits, bits since grid point, commas seen, errors.
    int m_hist = 0;
    int m_pos  = 0;
    int m_seen = 0;
    int m_err  = 0;
    int m_out  = 0;
    bit m_lock  = 1'b0;
    bit m_valid = 1'b0;
    bit m_isc   = 1'b0;

    always #5 reloj = ~reloj;

    comma_align #(
        .LOCK_COMMAS (LOCKN),
        .MAX_ERR     (MAXE)
    ) dut (
        .reloj      (reloj),
        .reset      (reset),
        .data_in    (data_in),
        .rxpol      (rxpol),
        .data_out   (data_out),
        .data_valid (data_valid),
        .is_comma   (is_comma),
        .locked     (locked)
    );

    function automatic void model_reset();
        m_hist  = 0;
        m_pos   = 0;
        m_seen  = 0;
        m_err   = 0;
        m_out   = 0;
        m_lock  = 1'b0;
        m_valid = 1'b0;
        m_isc   = 1'b0;
    endfunction

    // One clock of the receiver as described by the rules, in terms of whole words.
    function automatic void model_step(input bit b);
        bit is_k     = (m_hist == int'(KN)) || (m_hist == int'(KP));
        bit at_bound = (m_pos == 0);
        m_valid = m_lock && at_bound;
        if (m_valid) begin
            m_out = m_hist;
            m_isc = is_k;
        end
        m_pos = (m_pos + 1) % 10;
        if (m_lock) begin
            if (is_k && !at_bound) begin
                m_err = m_err + 1;
                if (m_err == MAXE) begin
                    m_lock = 1'b0;
                    m_seen = 0;
                    m_err  = 0;
                    m_pos  = 0;
                end
            end else if (is_k) begin
                m_err = 0;
            end
        end else if (is_k && (m_seen == 0 || !at_bound)) begin
            m_pos  = 1;
            m_seen = 1;
            m_lock = (LOCKN == 1);
        end else if (is_k) begin
            m_seen = m_seen + 1;
            m_lock = (m_seen == LOCKN);
        end
        m_hist = (m_hist >> 1) | (int'(b) << 9);
    endfunction

    task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s bit=%0d observed=%h expected=%h", tag, bitn, obs, expv);
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs == expv) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic check_outputs();
        chk10("locked", 10'(locked), 10'(m_lock));
        chk10("data_valid", 10'(data_valid), 10'(m_valid));
        chk10("data_out", data_out, 10'(m_out));
        chk10("is_comma", 10'(is_comma), 10'(m_isc));
    endtask

    task automatic clear_log();
        bitn     = 0;
        lock_bit = -1;
        pv_bit.delete();
        pv_data.delete();
        pv_comma.delete();
    endtask

    // Drive one line bit, let the edge happen, then compare just after it.
    task automatic clk_bit(input logic line);
        logic eff;
        data_in = line;
        eff     = line ^ rxpol;
        @(posedge reloj);
        model_step(eff);
        #1;
        bitn++;
        check_outputs();
        if (data_valid === 1'b1) begin
            pv_bit.push_back(bitn);
            pv_data.push_back(data_out);
            pv_comma.push_back(is_comma);
        end
        if (locked === 1'b1 && lock_bit < 0) lock_bit = bitn;
        if (locked !== 1'b1) unlocked_cycles++;
    endtask

    // Send bits lo..hi of an effective word; the line carries them inverted when rxpol is set.
    task automatic send_bits(input logic [9:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) clk_bit(w[i] ^ rxpol);
    endtask

    task automatic send_word(input logic [9:0] w);
        send_bits(w, 0, 9);
    endtask

    task automatic send_fill(input int n);
        for (int i = 0; i < n; i++) clk_bit(((i % 2) == 0) ^ rxpol);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge reloj);
        #1;
        reset = 1'b0;
        clear_log();
    endtask

    task automatic acquire(input logic [2:0] junk, input string tag);
        for (int i = 0; i < 3; i++) clk_bit(junk[i] ^ rxpol);
        repeat (4) send_word(KN);
        send_word(D155);
        send_word(KN);
        chk_int({tag, "_lock_bit"}, lock_bit, 34);
        chk_int({tag, "_pulses"}, pv_bit.size(), 2);
        if (pv_bit.size() == 2) begin
            chk_int({tag, "_p0_bit"}, pv_bit[0], 44);
            chk10({tag, "_p0_data"}, pv_data[0], KN);
            chk10({tag, "_p0_comma"}, 10'(pv_comma[0]), 10'd1);
            chk_int({tag, "_p1_bit"}, pv_bit[1], 54);
            chk10({tag, "_p1_data"}, pv_data[1], D155);
            chk10({tag, "_p1_comma"}, 10'(pv_comma[1]), 10'd0);
        end
    endtask

    initial begin
        logic [2:0]  junk;
        int          quiet;
        int unsigned r;
        int unsigned sel;
        logic [9:0]  w;

        junk = 3'($urandom);

        // Acquisition, normal polarity.
        rxpol = 1'b0;
        do_reset();
        acquire(junk, "A");

        // Same stream inverted on the line, corrected by rxpol.
        rxpol = 1'b1;
        do_reset();
        acquire(junk, "B");

        // Slip by one bit while locked: four misaligned commas drop lock, three relock.
        clk_bit(1'($urandom));
        for (int i = 0; i < 7; i++) begin
            send_word(KN);
            chk10($sformatf("C_locked_w%0d", i), 10'(locked), 10'(i < 4));
        end
        clk_bit(rxpol);
        chk10("C_relocked", 10'(locked), 10'd1);
        quiet = 0;
        foreach (pv_bit[k]) if (pv_bit[k] >= 105 && pv_bit[k] <= 135) quiet++;
        chk_int("C_no_valid_unlocked", quiet, 0);

        // Three misaligned commas then an aligned one clears the error count.
        unlocked_cycles = 0;
        repeat (3) send_word(KN);
        send_fill(9);
        send_word(KN);
        clk_bit(rxpol);
        repeat (3) send_word(KN);
        send_fill(9);
        repeat (2) send_word(KN);
        chk_int("D_unlocked_cycles", unlocked_cycles, 0);

        // Reset five bits into a locked word.
        send_bits(D155, 0, 4);
        chk10("E_locked_before", 10'(locked), 10'd1);
        #2;
        do_reset();
        send_bits(D155, 5, 9);
        repeat (2) send_word(D155);
        repeat (4) send_word(KN);
        send_word(D155);
        send_word(KN);
        chk_int("E_lock_bit", lock_bit, 56);
        chk_int("E_pulses", pv_bit.size(), 2);
        if (pv_bit.size() == 2) begin
            chk_int("E_p0_bit", pv_bit[0], 66);
            chk10("E_p0_data", pv_data[0], KN);
            chk_int("E_p1_bit", pv_bit[1], 76);
            chk10("E_p1_data", pv_data[1], D155);
        end

        // SYNC realign: a comma four bits off the grid restarts the count.
        rxpol = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) clk_bit(junk[i]);
        repeat (2) send_word(KN);
        send_fill(4);
        repeat (3) send_word(KN);
        clk_bit(1'b0);
        chk_int("G_lock_bit", lock_bit, 58);
        chk_int("G_pulses", pv_bit.size(), 0);

        // Random soak: mixed commas, data, slips and polarity flips.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                sel = $urandom_range(1, 9);
                for (int i = 0; i < int'(sel); i++) clk_bit(1'($urandom));
            end
            if (r >= 94) rxpol = ~rxpol;
            sel = $urandom_range(0, 9);
            if (sel < 4) w = KN;
            else if (sel < 6) w = KP;
            else w = 10'($urandom);
            send_word(w);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
